// File: rtl/fact_cu.sv
// fact_cu: Moore FSM that sequences the factorial datapath (counter, product register) for one n! per start request.
//   Ports: clk, rst (async, active-low), go (start on rising edge), gt_in (n > 12), gt_fact (counter > 1)
//          -> load_cnt, en, sel_1, load_reg, sel_2 (datapath strobes), busy, done, err (status).
//   Optional (macro FACT_CU_CYCLE_CNT_EN): parameter CNT_W and output cycles[CNT_W-1:0], the edges taken by the last run.
module fact_cu
`ifdef FACT_CU_CYCLE_CNT_EN
  #(parameter int CNT_W = 8)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic gt_in,
  input  logic gt_fact,
  output logic load_cnt,
  output logic en,
  output logic sel_1,
  output logic load_reg,
  output logic sel_2,
  output logic busy,
  output logic done,
  output logic err
`ifdef FACT_CU_CYCLE_CNT_EN
  ,
  output logic [CNT_W-1:0] cycles
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, MUL, DONE, ERR} state_t;
  state_t state, state_n;
  logic go_q, start;
  assign start = go & ~go_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      go_q <= 1'b0;
    end else begin
      state <= state_n;
      go_q <= go;
    end
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE, DONE, ERR: state_n = start ? (gt_in ? ERR : LOAD) : state;
      LOAD:            state_n = CHECK;
      CHECK:           state_n = gt_fact ? MUL : DONE;
      MUL:             state_n = CHECK;
      default:         state_n = IDLE;
    endcase
  end
  assign load_cnt = state == LOAD;
  assign en       = state == MUL;
  assign sel_1    = state == MUL;
  assign load_reg = state == LOAD || state == MUL;
  assign sel_2    = state == DONE;
  assign done     = state == DONE;
  assign err      = state == ERR;
  assign busy     = state == LOAD || state == CHECK || state == MUL;
`ifdef FACT_CU_CYCLE_CNT_EN
  logic [CNT_W-1:0] cnt, cnt_inc;
  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  // DONE is only entered from CHECK (busy), so the latched value includes that final edge.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      cycles <= '0;
    end else begin
      if (state_n == LOAD) cnt <= '0;
      else if (busy) cnt <= cnt_inc;
      if (state == CHECK && state_n == DONE) cycles <= cnt_inc;
    end
`endif
endmodule

// File: tb/tb_fact_cu.sv
// tb_fact_cu: scoreboard bench for fact_cu with a behavioural datapath model.
module tb_fact_cu;
  logic clk = 1'b0, rst = 1'b0, go = 1'b0;
  logic gt_in, gt_fact, load_cnt, en, sel_1, load_reg, sel_2, busy, done, err;
  logic [31:0] n = 0, dcnt = 0, prod = 0, nf;
  int total = 0, bad = 0;
`ifdef FACT_CU_CYCLE_CNT_EN
  logic [7:0] cycles;
  int last_cycles = 0;
`endif
  typedef struct {bit e; logic [31:0] nf; int lat; int muls;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  fact_cu dut (
    .clk(clk), .rst(rst), .go(go), .gt_in(gt_in), .gt_fact(gt_fact),
    .load_cnt(load_cnt), .en(en), .sel_1(sel_1), .load_reg(load_reg),
    .sel_2(sel_2), .busy(busy), .done(done), .err(err)
`ifdef FACT_CU_CYCLE_CNT_EN
    , .cycles(cycles)
`endif
  );
  assign gt_in = n > 12;
  assign gt_fact = dcnt > 1;
  assign nf = sel_2 ? prod : 32'd0;
  always @(posedge clk) begin
    if (load_cnt) dcnt <= n;
    else if (en) dcnt <= dcnt - 1;
    if (load_reg) prod <= sel_1 ? prod * dcnt : 32'd1;
  end
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, want);
    end
  endtask
  function automatic exp_t model(input int k);
    exp_t m;
    m.e = k > 12;
    m.nf = 1;
    for (int i = 2; i <= k; i++) m.nf = m.nf * i;
    if (m.e) m.nf = 0;
    m.lat = m.e ? 0 : (k < 2 ? 2 : 2 * k);
    m.muls = (m.e || k < 2) ? 0 : k - 1;
    return m;
  endfunction
  task automatic run(input int k, input bit pulse_mid);
    int lat = 0, muls = 0, busys = 0, s2b = 0, strobes = 0;
    logic d1 = 1'b1;
    exp_t e;
    n = k;
    go = 0;
    @(negedge clk);
    go = 1;
    q.push_back(model(k));
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) d1 = done;
      muls += int'(en);
      busys += int'(busy);
      if (busy && sel_2) s2b++;
      if (load_cnt || load_reg || en) strobes++;
      if (pulse_mid && lat == 3) go = 0;
      if (pulse_mid && lat == 4) go = 1;
    end while (!(done || err) && lat < 200);
    chk($sformatf("finished n=%0d", k), done | err, 1);
    chk($sformatf("done_drop n=%0d", k), d1, 0);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("err n=%0d", k), err, e.e);
      chk($sformatf("done n=%0d", k), done, !e.e);
      chk($sformatf("nf n=%0d", k), nf, e.nf);
      chk($sformatf("latency n=%0d", k), lat - 1, e.lat);
      chk($sformatf("muls n=%0d", k), muls, e.muls);
      chk($sformatf("busy_cycles n=%0d", k), busys, e.lat);
      chk($sformatf("sel2_busy n=%0d", k), s2b, 0);
      if (e.e) chk($sformatf("err_strobes n=%0d", k), strobes, 0);
`ifdef FACT_CU_CYCLE_CNT_EN
      if (!e.e) last_cycles = e.lat;
      chk($sformatf("cycles n=%0d", k), cycles, last_cycles);
`endif
    end
  endtask
  initial begin
    int held_busy = 0, held_ndone = 0, held_strobe = 0, m = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {load_cnt, en, sel_1, load_reg, sel_2, busy, done, err}, 0);
`ifdef FACT_CU_CYCLE_CNT_EN
    chk("reset_cycles", cycles, 0);
`endif
    rst = 1;
    @(negedge clk);
    run(5, 0);
    run(0, 0);
    run(1, 0);
    run(12, 0);
    run(13, 0);
    repeat (5) begin
      @(negedge clk);
      if (load_cnt || load_reg || en) held_strobe++;
    end
    chk("err_hold_strobes", held_strobe, 0);
    chk("err_hold", err, 1);
    run(3, 1);
    repeat (30) begin
      @(negedge clk);
      held_busy += int'(busy);
      held_ndone += int'(!done);
    end
    chk("held_busy", held_busy, 0);
    chk("held_done", held_ndone, 0);
    run(4, 0);
    n = 6;
    go = 0;
    @(negedge clk);
    go = 1;
    for (int i = 0; i < 40 && m < 2; i++) begin
      @(negedge clk);
      m += int'(en);
    end
    chk("second_mul_reached", m, 2);
    #2 rst = 0;
    #1 chk("async_reset_outputs", {load_cnt, en, sel_1, load_reg, sel_2, busy, done, err}, 0);
    @(negedge clk);
    rst = 1;
    go = 0;
    @(negedge clk);
    chk("post_reset_done", done, 0);
    chk("post_reset_nf", nf, 0);
    chk("post_reset_busy", busy, 0);
`ifdef FACT_CU_CYCLE_CNT_EN
    last_cycles = 0;
    chk("post_reset_cycles", cycles, 0);
`endif
    run(2, 0);
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
